rsa_cmd_responder: RTL

RSA_CMD_RESPONDER -- requirements
Module: rsa_cmd_responder

---
 rtl/rsa_cmd_pkg.sv | 48 ++++
 rtl/rsa_cmd_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rsa_cmd_pkg.sv
// Shared definitions for the RSA command responder: instruction codes, COMMAND
// and status bit positions, operand slot indices and the responder state set.
package rsa_cmd_pkg;

    localparam logic [2:0] INSTR_IDLE      = 3'd0;
    localparam logic [2:0] INSTR_COMP      = 3'd1;
    localparam logic [2:0] INSTR_READ_IN   = 3'd2;
    localparam logic [2:0] INSTR_WRITE_OUT = 3'd3;
    localparam logic [2:0] INSTR_ENCRYPT   = 3'd4;
    localparam logic [2:0] INSTR_DECRYPT   = 3'd5;

    localparam int CMD_INSTR_LSB   = 0;
    localparam int CMD_DATA_VALID  = 3;
    localparam int CMD_DONE_ACK    = 7;
    localparam int CMD_VALID       = 8;
    localparam int CMD_DATA_READY  = 9;
    localparam int CMD_PCNT_LSB    = 14;
    localparam int CMD_PARAM_VALID = 17;

    localparam int STAT_TX_READY    = 4;
    localparam int STAT_DATA_READY  = 5;
    localparam int STAT_IS_DONE     = 6;
    localparam int STAT_PARAM_READY = 18;
    localparam int STAT_CMD_READY   = 19;
    localparam int STAT_ERR         = 20;

    localparam logic [2:0] PARAM_N      = 3'd0;
    localparam logic [2:0] PARAM_RMODN  = 3'd1;
    localparam logic [2:0] PARAM_M      = 3'd2;
    localparam logic [2:0] PARAM_R2MODN = 3'd3;
    localparam logic [2:0] PARAM_E      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ACK,
        ST_RX_WAIT,
        ST_RX_BUSY,
        ST_CORE_BUSY,
        ST_TX_WAIT,
        ST_TX_BUSY,
        ST_DONE
    } state_t;

    function automatic logic param_in_range(input logic [2:0] cnt);
        return (cnt <= PARAM_E);
    endfunction

endpackage

// File: rtl/rsa_cmd_responder.sv
// Host command responder: registers the COMMAND word, sequences DMA/core work
// for each accepted instruction and reports progress through status_out.
module rsa_cmd_responder
    import rsa_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] host_cmd,
    output logic [31:0] status_out,
    output logic        dma_rx_start,
    output logic        dma_tx_start,
    input  logic        dma_rx_done,
    input  logic        dma_tx_done,
    output logic        core_start,
    output logic        core_mode,
    input  logic        core_done,
    output logic [2:0]  param_sel
);

    logic [31:0] cmd_r;
    logic        prev_valid_r;
    logic [2:0]  last_instr_r;
    state_t      state_r;
    logic        tx_ready_r, data_ready_r, is_done_r;
    logic        param_ready_r, cmd_ready_r, err_r;
    logic        dma_rx_start_r, dma_tx_start_r, core_start_r, core_mode_r;
    logic [2:0]  param_sel_r;
    logic [31:0] status_s;

    logic [2:0] instr_s;
    logic [2:0] pcnt_s;
    logic       data_valid_s, done_ack_s, cmd_valid_s, data_ready_in_s, param_valid_s;
    logic       accept_s;
    logic       unused_cmd_bits_s;

    assign instr_s         = cmd_r[CMD_INSTR_LSB +: 3];
    assign pcnt_s          = cmd_r[CMD_PCNT_LSB +: 3];
    assign data_valid_s    = cmd_r[CMD_DATA_VALID];
    assign done_ack_s      = cmd_r[CMD_DONE_ACK];
    assign cmd_valid_s     = cmd_r[CMD_VALID];
    assign data_ready_in_s = cmd_r[CMD_DATA_READY];
    assign param_valid_s   = cmd_r[CMD_PARAM_VALID];
    assign unused_cmd_bits_s = ^{cmd_r[31:18], cmd_r[13:10], cmd_r[6:4]};

    // A held-high valid re-triggers only when the instruction code changes.
    assign accept_s = (state_r == ST_IDLE) && cmd_valid_s && !done_ack_s &&
                      (!prev_valid_r || (instr_s != last_instr_r));

    // Status word assembly from the registered flags.
    always_comb begin
        status_s                   = 32'd0;
        status_s[STAT_TX_READY]    = tx_ready_r;
        status_s[STAT_DATA_READY]  = data_ready_r;
        status_s[STAT_IS_DONE]     = is_done_r;
        status_s[STAT_PARAM_READY] = param_ready_r;
        status_s[STAT_CMD_READY]   = cmd_ready_r;
        status_s[STAT_ERR]         = err_r;
    end

    assign status_out   = status_s;
    assign dma_rx_start = dma_rx_start_r;
    assign dma_tx_start = dma_tx_start_r;
    assign core_start   = core_start_r;
    assign core_mode    = core_mode_r;
    assign param_sel    = param_sel_r;

    // Command register, handshake flags and the responder state machine.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_r          <= 32'd0;
            prev_valid_r   <= 1'b0;
            last_instr_r   <= INSTR_IDLE;
            state_r        <= ST_IDLE;
            tx_ready_r     <= 1'b0;
            data_ready_r   <= 1'b0;
            is_done_r      <= 1'b0;
            param_ready_r  <= 1'b0;
            cmd_ready_r    <= 1'b0;
            err_r          <= 1'b0;
            dma_rx_start_r <= 1'b0;
            dma_tx_start_r <= 1'b0;
            core_start_r   <= 1'b0;
            core_mode_r    <= 1'b0;
            param_sel_r    <= PARAM_N;
        end else begin
            cmd_r          <= host_cmd;
            prev_valid_r   <= cmd_valid_s;
            dma_rx_start_r <= 1'b0;
            dma_tx_start_r <= 1'b0;
            core_start_r   <= 1'b0;

            // Flag clears come first so a same-cycle set below takes priority.
            if (!data_valid_s)    data_ready_r  <= 1'b0;
            if (!data_ready_in_s) tx_ready_r    <= 1'b0;
            if (!param_valid_s)   param_ready_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (param_valid_s) begin
                        param_ready_r <= 1'b1;
                        if (param_in_range(pcnt_s)) param_sel_r <= pcnt_s;
                        else                        err_r       <= 1'b1;
                    end
                    if (accept_s) begin
                        last_instr_r <= instr_s;
                        cmd_ready_r  <= 1'b1;
                        state_r      <= ST_CMD_ACK;
                    end
                end
                ST_CMD_ACK: begin
                    case (last_instr_r)
                        INSTR_READ_IN:   state_r <= ST_RX_WAIT;
                        INSTR_WRITE_OUT: state_r <= ST_TX_WAIT;
                        INSTR_ENCRYPT, INSTR_DECRYPT: begin
                            core_start_r <= 1'b1;
                            core_mode_r  <= last_instr_r[0];
                            state_r      <= ST_CORE_BUSY;
                        end
                        INSTR_IDLE, INSTR_COMP: begin
                            is_done_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                        default: begin
                            err_r     <= 1'b1;
                            is_done_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    endcase
                end
                ST_RX_WAIT: begin
                    if (data_valid_s) begin
                        dma_rx_start_r <= 1'b1;
                        data_ready_r   <= 1'b1;
                        state_r        <= ST_RX_BUSY;
                    end
                end
                ST_RX_BUSY: begin
                    if (dma_rx_done) begin
                        is_done_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_CORE_BUSY: begin
                    if (core_done) begin
                        is_done_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_TX_WAIT: begin
                    if (data_ready_in_s) begin
                        dma_tx_start_r <= 1'b1;
                        state_r        <= ST_TX_BUSY;
                    end
                end
                ST_TX_BUSY: begin
                    if (dma_tx_done) begin
                        tx_ready_r <= 1'b1;
                        is_done_r  <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_ack_s) begin
                        is_done_r   <= 1'b0;
                        err_r       <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
